// File: rtl/cache_route_issue_if.sv
// Request and selector-side signal bundle for the cache route issue front end.
// The master side offers requests and returns the async fire/done toggles.
interface cache_route_issue_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_hit;
   logic              sel_valid0;
   logic              sel_valid1;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_drive;
   logic              sel_fire_t;
   logic              done_t;

   modport master (
      output req_valid, req_addr, req_hit, sel_fire_t, done_t,
      input  req_ready, sel_valid0, sel_valid1, sel_addr, sel_drive
   );

   modport slave (
      input  req_valid, req_addr, req_hit, sel_fire_t, done_t,
      output req_ready, sel_valid0, sel_valid1, sel_addr, sel_drive
   );
endinterface

// File: rtl/cache_route_issue.sv
// Buffers cache requests and issues each one to the two-way click selector:
// one-hot route valids, a 2-phase drive toggle, retire on fire then done.
module cache_route_issue #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic                   clk,
   input  logic                   rst,
   cache_route_issue_if.slave     bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_proto,
   output logic                   err_timeout
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit WD_EN = (TIMEOUT > 0);
   localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [AW-1:0]   PTR_ONE = AW'(1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETUP     = 3'd1,
      LAUNCH    = 3'd2,
      SEL_WAIT  = 3'd3,
      DONE_WAIT = 3'd4
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic [ADDR_W-1:0] addr_mem_r [DEPTH];
   logic [DEPTH-1:0]  hit_mem_r;
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic [CW-1:0]     count_nxt_s;
   logic              ready_r;
   logic              push_s;
   logic              pop_s;
   logic [SYNC_STAGES-1:0] fire_sync_r;
   logic [SYNC_STAGES-1:0] done_sync_r;
   logic              fire_prev_r;
   logic              done_prev_r;
   logic              fire_edge_r;
   logic              done_edge_r;
   logic              sel_valid0_r;
   logic              sel_valid1_r;
   logic [ADDR_W-1:0] sel_addr_r;
   logic              sel_drive_r;
   logic              busy_r;
   logic              err_proto_r;
   logic              err_timeout_r;
   logic [WD_W-1:0]   wd_r;
   logic              waiting_s;

   assign push_s    = bus.req_valid && ready_r;
   assign pop_s     = (state_r == DONE_WAIT) && done_edge_r;
   assign waiting_s = (state_r == SEL_WAIT) || (state_r == DONE_WAIT);

   assign bus.req_ready  = ready_r;
   assign bus.sel_valid0 = sel_valid0_r;
   assign bus.sel_valid1 = sel_valid1_r;
   assign bus.sel_addr   = sel_addr_r;
   assign bus.sel_drive  = sel_drive_r;
   assign busy           = busy_r;
   assign count          = count_r;
   assign err_proto      = err_proto_r;
   assign err_timeout    = err_timeout_r;

   // Occupancy update; ready is registered from it, so a full FIFO never bypasses.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Request storage, data only.
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_mem_r[wr_ptr_r] <= bus.req_addr;
         hit_mem_r[wr_ptr_r]  <= bus.req_hit;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         ready_r  <= 1'b1;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         count_r <= count_nxt_s;
         ready_r <= (count_nxt_s < FULL_C);
      end
   end

   // Toggle synchronizers and registered one-cycle edge pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         fire_sync_r <= '0;
         done_sync_r <= '0;
         fire_prev_r <= 1'b0;
         done_prev_r <= 1'b0;
         fire_edge_r <= 1'b0;
         done_edge_r <= 1'b0;
      end else begin
         fire_sync_r <= {fire_sync_r[SYNC_STAGES-2:0], bus.sel_fire_t};
         done_sync_r <= {done_sync_r[SYNC_STAGES-2:0], bus.done_t};
         fire_prev_r <= fire_sync_r[SYNC_STAGES-1];
         done_prev_r <= done_sync_r[SYNC_STAGES-1];
         fire_edge_r <= fire_sync_r[SYNC_STAGES-1] ^ fire_prev_r;
         done_edge_r <= done_sync_r[SYNC_STAGES-1] ^ done_prev_r;
      end
   end

   // Issue sequencing state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= next_state_s;
   end

   // Next-state logic; stray edges are flagged elsewhere and do not move the FSM.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (count_r != '0) next_state_s = SETUP;
            else               next_state_s = IDLE;
         end
         SETUP:  next_state_s = LAUNCH;
         LAUNCH: next_state_s = SEL_WAIT;
         SEL_WAIT: begin
            if (fire_edge_r) next_state_s = DONE_WAIT;
            else             next_state_s = SEL_WAIT;
         end
         DONE_WAIT: begin
            if (done_edge_r) next_state_s = IDLE;
            else             next_state_s = DONE_WAIT;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Selector outputs: route loads entering SETUP, drive toggles entering LAUNCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_valid0_r <= 1'b0;
         sel_valid1_r <= 1'b0;
         sel_addr_r   <= '0;
         sel_drive_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         if ((state_r == IDLE) && (count_r != '0)) begin
            sel_addr_r   <= addr_mem_r[rd_ptr_r];
            sel_valid0_r <= hit_mem_r[rd_ptr_r];
            sel_valid1_r <= ~hit_mem_r[rd_ptr_r];
         end else if (pop_s) begin
            sel_valid0_r <= 1'b0;
            sel_valid1_r <= 1'b0;
         end
         if (state_r == SETUP) sel_drive_r <= ~sel_drive_r;
         busy_r <= (next_state_s != IDLE);
      end
   end

   // Watchdog restarts on each wait-state entry and saturates; errors are sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_r          <= '0;
         err_proto_r   <= 1'b0;
         err_timeout_r <= 1'b0;
      end else begin
         if ((state_r == LAUNCH) || ((state_r == SEL_WAIT) && fire_edge_r)) begin
            wd_r <= '0;
         end else if (waiting_s && (wd_r != WD_MAX)) begin
            wd_r <= wd_r + WD_ONE;
         end
         if (WD_EN && waiting_s && (wd_r == WD_MAX)) err_timeout_r <= 1'b1;
         if ((fire_edge_r && (state_r != SEL_WAIT)) ||
             (done_edge_r && (state_r != DONE_WAIT))) begin
            err_proto_r <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cache_route_issue.sv
// Randomized scoreboard bench: accepted requests queue their expected route,
// a monitor checks each drive launch, a responder plays the selector and path.
module tb_cache_route_issue;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int TMO   = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [2:0] count;
   logic       err_proto;
   logic       err_timeout;

   cache_route_issue_if #(.ADDR_W(AW)) ifc ();

   cache_route_issue #(
      .ADDR_W(AW), .DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .bus(ifc), .busy(busy), .count(count),
      .err_proto(err_proto), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [AW:0] exp_q[$];
   int          launches = 0;
   int          served = 0;
   bit          resp_en = 1'b0;
   logic        last_drive = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Called at a negedge; holds the request until accepted, then records it.
   task automatic push(input logic [AW-1:0] a, input logic h);
      bit acc = 1'b0;
      ifc.req_valid = 1'b1;
      ifc.req_addr  = a;
      ifc.req_hit   = h;
      for (int k = 0; k < 400 && !acc; k++) begin
         acc = (ifc.req_ready === 1'b1);
         @(negedge clk);
      end
      ifc.req_valid = 1'b0;
      if (acc) exp_q.push_back({h, a});
      else     chk("push_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int k = 0; k < 3000 && !ok; k++) begin
         ok = !busy && (count == 3'd0) && (exp_q.size() == 0) && (served == launches);
         if (!ok) @(negedge clk);
      end
      chk("drain_done", ok, 1'b1);
   endtask

   task automatic wait_launch(input int target);
      bit ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = (launches >= target);
      end
      chk("launch_seen", ok, 1'b1);
   endtask

   // Monitor: every drive toggle must present the oldest outstanding request.
   initial begin
      logic [AW:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_drive = 1'b0;
         end else begin
            chk("onehot", ifc.sel_valid0 && ifc.sel_valid1, 1'b0);
            chk("count_bound", count <= 3'd4, 1'b1);
            if (ifc.sel_drive !== last_drive) begin
               last_drive = ifc.sel_drive;
               launches++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_launch", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("launch_addr", ifc.sel_addr, e[AW-1:0]);
                  chk("launch_v0", ifc.sel_valid0, e[AW]);
                  chk("launch_v1", ifc.sel_valid1, !e[AW]);
               end
            end
         end
      end
   end

   // Responder: selector fires a little after drive, the path completes later.
   initial begin
      forever begin
         @(negedge clk);
         if (resp_en && !rst && (served < launches)) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            ifc.sel_fire_t = ~ifc.sel_fire_t;
            repeat (5) @(negedge clk);
            ifc.done_t = ~ifc.done_t;
            served++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      rst = 1'b1;
      ifc.req_valid  = 1'b1;
      ifc.req_addr   = 32'hDEAD_BEEF;
      ifc.req_hit    = 1'b1;
      ifc.sel_fire_t = 1'b0;
      ifc.done_t     = 1'b0;

      // Reset held with a request offered
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_ready", ifc.req_ready, 1'b1);
         chk("rst_count", count, 3'd0);
         chk("rst_drive", ifc.sel_drive, 1'b0);
         chk("rst_valids", {ifc.sel_valid0, ifc.sel_valid1}, 2'b00);
      end
      @(negedge clk);
      rst = 1'b0;
      ifc.req_valid = 1'b0;
      @(negedge clk);
      chk("rst_no_push", count, 3'd0);
      chk("rst_busy", busy, 1'b0);

      // Single hit with latency
      resp_en = 1'b1;
      push(32'h0000_1000, 1'b1);
      chk("t2_count", count, 3'd1);
      @(negedge clk);
      chk("t2_v0_setup", ifc.sel_valid0, 1'b1);
      chk("t2_v1_setup", ifc.sel_valid1, 1'b0);
      chk("t2_addr_setup", ifc.sel_addr, 32'h0000_1000);
      chk("t2_drive_before", ifc.sel_drive, 1'b0);
      @(negedge clk);
      chk("t2_drive_toggled", ifc.sel_drive, 1'b1);
      drain();
      chk("t2_valids_drop", {ifc.sel_valid0, ifc.sel_valid1}, 2'b00);

      // Fill with no responder, fifth push held off
      resp_en = 1'b0;
      for (int i = 0; i < 4; i++) push(32'h0000_2000 + 32'(i * 16), 1'b0);
      chk("t3_full_count", count, 3'd4);
      chk("t3_full_ready", ifc.req_ready, 1'b0);
      ifc.req_valid = 1'b1;
      ifc.req_addr  = 32'h0000_2040;
      ifc.req_hit   = 1'b0;
      repeat (2) @(negedge clk);
      chk("t3_held_count", count, 3'd4);
      chk("t3_held_ready", ifc.req_ready, 1'b0);
      resp_en = 1'b1;
      push(32'h0000_2040, 1'b0);
      drain();

      // Alternating routes with random gaps, wrapping the pointers
      for (int i = 0; i < 10; i++) begin
         push($urandom, i[0]);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      drain();
      chk("t4_no_proto", err_proto, 1'b0);
      chk("t4_no_timeout", err_timeout, 1'b0);

      // Early done toggle in SEL_WAIT is flagged and ignored
      resp_en = 1'b0;
      n = launches;
      push(32'h0000_5000, 1'b1);
      wait_launch(n + 1);
      ifc.done_t = ~ifc.done_t;
      repeat (5) @(negedge clk);
      chk("t5_proto_set", err_proto, 1'b1);
      chk("t5_still_busy", busy, 1'b1);
      chk("t5_not_popped", count, 3'd1);
      chk("t5_valid_held", ifc.sel_valid0, 1'b1);
      ifc.sel_fire_t = ~ifc.sel_fire_t;
      repeat (5) @(negedge clk);
      ifc.done_t = ~ifc.done_t;
      repeat (6) @(negedge clk);
      served++;
      chk("t5_retired", count, 3'd0);
      chk("t5_idle", busy, 1'b0);
      chk("t5_valid_drop", ifc.sel_valid0, 1'b0);

      // Watchdog then reset mid-wait
      n = launches;
      push(32'h0000_6000, 1'b0);
      wait_launch(n + 1);
      repeat (7) @(negedge clk);
      chk("t6_no_early_timeout", err_timeout, 1'b0);
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = err_timeout;
         end
         chk("t6_timeout_set", seen, 1'b1);
      end
      chk("t6_still_waiting", busy, 1'b1);
      rst = 1'b1;
      ifc.sel_fire_t = 1'b0;
      ifc.done_t     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_rst_proto", err_proto, 1'b0);
      chk("t6_rst_timeout", err_timeout, 1'b0);
      chk("t6_rst_count", count, 3'd0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_ready", ifc.req_ready, 1'b1);
      chk("t6_rst_drive", ifc.sel_drive, 1'b0);
      chk("t6_rst_valids", {ifc.sel_valid0, ifc.sel_valid1}, 2'b00);
      chk("t6_rst_addr", ifc.sel_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      served = launches;
      @(negedge clk);

      // Recovery after reset
      resp_en = 1'b1;
      push(32'h0000_7000, 1'b1);
      drain();
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_no_proto", err_proto, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
